// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Parametrised two-stage pipelined ALU with valid/ready flow
//               control. Stage 1 registers the operands and opcode. Stage 2
//               computes and registers the result and status flags.
//
//               Ports:
//                 clk, rst              clock, synchronous active-high reset
//                 in_valid / in_ready   input handshake (in_ready is combinational)
//                 a, b, c_in, operation operands, carry-in, 4-bit opcode
//                 out_valid / out_ready output handshake
//                 result                registered result
//                 c_out, overflow       adder flags (ADD/SUB only, else 0)
//                 zero, negative        result == 0, result MSB
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam logic [3:0] c_OP_PASS = 4'd0;
    localparam logic [3:0] c_OP_NOT  = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_AND  = 4'd5;
    localparam logic [3:0] c_OP_SLT  = 4'd6;
    localparam logic [3:0] c_OP_XOR  = 4'd8;
    localparam logic [3:0] c_OP_NOR  = 4'd9;
    localparam logic [3:0] c_OP_SLTU = 4'd10;
    localparam logic [3:0] c_OP_SLL  = 4'd11;
    localparam logic [3:0] c_OP_SRL  = 4'd12;
    localparam logic [3:0] c_OP_SRA  = 4'd13;

    // Stage 1 registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic [3:0]       r_s1_op;

    // Stage 2 (output) registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_c_out;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;

    // Flow control
    logic w_s2_adv;
    logic w_s1_adv;

    // Datapath
    logic             w_is_addsub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_add_ext;
    logic             w_add_ovf;
    logic [WIDTH:0]   w_cmp_ext;
    logic             w_cmp_ovf;
    logic             w_slt;
    logic             w_sltu;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_res;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_comb begin
        w_is_addsub = (r_s1_op == c_OP_ADD) || (r_s1_op == c_OP_SUB);
        w_b_eff     = (r_s1_op == c_OP_SUB) ? ~r_s1_b : r_s1_b;
        w_add_ext   = {1'b0, r_s1_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_s1_cin};
        w_add_ovf   = (r_s1_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_add_ext[WIDTH-1] != r_s1_a[WIDTH-1]);

        // Compares use a dedicated a-b (carry-in fixed at 1) so they do not
        // depend on c_in. The signed result corrects the sign bit with the
        // overflow so that e.g. MAX_POS vs -1 compares correctly.
        w_cmp_ext = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};
        w_cmp_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                    (w_cmp_ext[WIDTH-1] != r_s1_a[WIDTH-1]);
        w_slt     = w_cmp_ext[WIDTH-1] ^ w_cmp_ovf;
        w_sltu    = ~w_cmp_ext[WIDTH];

        w_shamt = r_s1_b[SHAMT_W-1:0];

        w_res = '0;
        case (r_s1_op)
            c_OP_PASS: w_res = r_s1_a;
            c_OP_NOT:  w_res = ~r_s1_a;
            c_OP_ADD:  w_res = w_add_ext[WIDTH-1:0];
            c_OP_SUB:  w_res = w_add_ext[WIDTH-1:0];
            c_OP_OR:   w_res = r_s1_a | r_s1_b;
            c_OP_AND:  w_res = r_s1_a & r_s1_b;
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
            c_OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            c_OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
            c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
            c_OP_SLL:  w_res = r_s1_a << w_shamt;
            c_OP_SRL:  w_res = r_s1_a >> w_shamt;
            c_OP_SRA:  w_res = $unsigned($signed(r_s1_a) >>> w_shamt);
            default:   w_res = '0;
        endcase
    end

    // Stage 1 valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
        end
    end

    // Stage 1 data: no reset needed, qualified by r_s1_valid
    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_s1_a   <= a;
            r_s1_b   <= b;
            r_s1_cin <= c_in;
            r_s1_op  <= operation;
        end
    end

    // Stage 2: result and flags only change when a valid op moves in, so a
    // drained pipeline keeps showing the last delivered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_c_out     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result   <= w_res;
                r_c_out    <= w_is_addsub && w_add_ext[WIDTH];
                r_overflow <= w_is_addsub && w_add_ovf;
                r_zero     <= (w_res == '0);
                r_negative <= w_res[WIDTH-1];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign c_out     = r_c_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign negative  = r_negative;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH=32). Vectors hold
//               operands and hand-derived results; accepted inputs push their
//               expected results to a scoreboard queue that is popped and
//               compared whenever the DUT delivers an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int WIDTH = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc_cyc;
    } sb_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [3:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    bit   chk_lat  = 1'b0;
    vec_t cur_exp;
    vec_t tv[$];
    sb_t  q[$];

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                                input logic cin, input logic [31:0] res,
                                input logic c, input logic o, input logic z, input logic n);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.cin = cin; v.res = res;
        v.c = c; v.o = o; v.z = z; v.n = n;
        return v;
    endfunction

    // Scoreboard: push on acceptance, pop and compare on delivery.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_t e;
                e.v = cur_exp;
                e.acc_cyc = cyc;
                q.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {32'h0, result}, 64'hDEAD_0000_0000_0000);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    chk($sformatf("result op%0d", e.v.op), {32'h0, result}, {32'h0, e.v.res});
                    chk($sformatf("flags{c,o,z,n} op%0d", e.v.op),
                        {60'h0, c_out, overflow, zero, negative},
                        {60'h0, e.v.c, e.v.o, e.v.z, e.v.n});
                    if (chk_lat)
                        chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        cur_exp   = v;
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        c_in      = v.cin;
        operation = v.op;
    endtask

    // Present a vector and hold it until accepted; returns at posedge+1.
    task automatic send(input vec_t v);
        bit acc;
        acc = 1'b0;
        drive(v);
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " out_valid"}, {63'h0, out_valid}, 64'd0);
        chk({tag, " result"}, {32'h0, result}, 64'd0);
        chk({tag, " flags"}, {60'h0, c_out, overflow, zero, negative}, 64'd0);
    endtask

    initial begin
        //       op     a             b             cin   result        c  o  z  n
        tv.push_back(mk(4'd2,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1, 0, 1, 0));
        tv.push_back(mk(4'd3,  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 0, 1, 0, 1));
        tv.push_back(mk(4'd6,  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 0, 0, 1, 0));
        tv.push_back(mk(4'd10, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 0, 0, 0, 0));
        tv.push_back(mk(4'd13, 32'h80000010, 32'h00000004, 1'b0, 32'hF8000001, 0, 0, 0, 1));
        tv.push_back(mk(4'd12, 32'h80000010, 32'h00000004, 1'b0, 32'h08000001, 0, 0, 0, 0));
        tv.push_back(mk(4'd11, 32'h80000010, 32'h00000000, 1'b0, 32'h80000010, 0, 0, 0, 1));
        tv.push_back(mk(4'd0,  32'h12345678, 32'h0000FFFF, 1'b1, 32'h12345678, 0, 0, 0, 0));
        tv.push_back(mk(4'd1,  32'h12345678, 32'h00000000, 1'b0, 32'hEDCBA987, 0, 0, 0, 1));
        tv.push_back(mk(4'd4,  32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 32'hFFFFF0F0, 0, 0, 0, 1));
        tv.push_back(mk(4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 0, 0, 0, 1));
        tv.push_back(mk(4'd7,  32'h00001234, 32'h00005678, 1'b1, 32'h00000000, 0, 0, 1, 0));
        tv.push_back(mk(4'd8,  32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 32'hF0F00F0F, 0, 0, 0, 1));
        tv.push_back(mk(4'd9,  32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 32'h00000F0F, 0, 0, 0, 0));
        tv.push_back(mk(4'd14, 32'h00000005, 32'h00000003, 1'b1, 32'h00000000, 0, 0, 1, 0));
        tv.push_back(mk(4'd3,  32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1, 0, 0, 0));
        tv.push_back(mk(4'd3,  32'h00000005, 32'h00000003, 1'b0, 32'h00000001, 1, 0, 0, 0));
        tv.push_back(mk(4'd2,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 0, 1, 0, 1));
        tv.push_back(mk(4'd6,  32'h80000000, 32'h00000001, 1'b1, 32'h00000001, 0, 0, 0, 0));
        tv.push_back(mk(4'd10, 32'h80000000, 32'h00000001, 1'b0, 32'h00000000, 0, 0, 1, 0));
        tv.push_back(mk(4'd2,  32'h00000003, 32'h00000004, 1'b1, 32'h00000008, 0, 0, 0, 0));
        tv.push_back(mk(4'd13, 32'h7FFFFFF0, 32'h00000024, 1'b0, 32'h07FFFFFF, 0, 0, 0, 0));
        tv.push_back(mk(4'd13, 32'h80000010, 32'h00000000, 1'b0, 32'h80000010, 0, 0, 0, 1));
        tv.push_back(mk(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 0, 0, 1, 0));

        // Reset
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; operation = 4'd0;
        cur_exp = tv[0];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset in_ready", {63'h0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream of every vector, no backpressure
        chk_lat = 1'b1;
        foreach (tv[i]) send(tv[i]);
        idle_in();
        drain();

        // Backpressure: stall output with a full pipeline, then release
        chk_lat = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 12; i < 18; i++) send(tv[i]);
                idle_in();
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall in_ready", {63'h0, in_ready}, 64'd0);
                for (int k = 0; k < 3; k++) begin
                    chk("stall out_valid", {63'h0, out_valid}, 64'd1);
                    chk("stall result", {32'h0, result}, {32'h0, tv[12].res});
                    chk("stall flags", {60'h0, c_out, overflow, zero, negative},
                        {60'h0, tv[12].c, tv[12].o, tv[12].z, tv[12].n});
                    chk("stall queue depth", 64'(q.size()), 64'd2);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight (S2 held by backpressure, S1 full)
        out_ready = 1'b0;
        send(tv[7]);
        send(tv[8]);
        rst = 1'b1;
        drive(tv[9]);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_in();
        out_ready = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", {63'h0, in_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk_idle_outputs("post-reset");
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // First op after reset completes with normal latency
        chk_lat = 1'b1;
        send(tv[17]);
        idle_in();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
